// File: rtl/mlp_pkg.sv
// Shared MLP constants and the layer-sequencer state encoding.
package mlp_pkg;

  localparam int MLP_NUM_LAYERS = 4;
  localparam int MLP_LAYER_W    = 4;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_FETCH    = 3'd1,
    SEQ_COMPUTE  = 3'd2,
    SEQ_ACTIVATE = 3'd3,
    SEQ_DONE     = 3'd4
  } mlp_seq_state_t;

endpackage

// File: rtl/mlp_layer_counter.sv
// Layer index register: clear, saturating increment and last-layer flag.
module mlp_layer_counter
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = MLP_NUM_LAYERS,
  parameter int LAYER_W    = MLP_LAYER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               incr,
  output logic [LAYER_W-1:0] layer,
  output logic               is_last
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  assign is_last = (layer == LAST_LAYER);

  // Saturates on the last layer so the index can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      layer <= '0;
    end else if (clear) begin
      layer <= '0;
    end else if (incr && !is_last) begin
      layer <= layer + LAYER_W'(1);
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Per-inference layer FSM. States: IDLE wait start | FETCH request weights |
// COMPUTE engine running | ACTIVATE relu + buffer swap | DONE completion pulse.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS = MLP_NUM_LAYERS,
  parameter int LAYER_W    = MLP_LAYER_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               wt_ready,
  input  logic               calc_done,
  output logic               busy,
  output logic               wt_req,
  output logic [LAYER_W-1:0] wt_layer,
  output logic               calc_start,
  output logic               act_en,
  output logic               buf_swap,
  output logic               done,
  output logic               aborted
);

  mlp_seq_state_t state, state_nxt;

  logic               first_q;
  logic               aborted_q;
  logic               abort_hit;
  logic               cnt_clear;
  logic               cnt_incr;
  logic               is_last;
  logic [LAYER_W-1:0] layer;

  assign abort_hit = abort && (state != SEQ_IDLE);

  mlp_layer_counter #(
    .NUM_LAYERS (NUM_LAYERS),
    .LAYER_W    (LAYER_W)
  ) u_layer_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .incr    (cnt_incr),
    .layer   (layer),
    .is_last (is_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // first_q marks the first COMPUTE cycle: it drives calc_start and masks calc_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      first_q   <= (state == SEQ_FETCH) && wt_ready && !abort;
      aborted_q <= abort_hit;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    if (abort_hit) begin
      state_nxt = SEQ_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            state_nxt = SEQ_FETCH;
            cnt_clear = 1'b1;
          end
        end
        SEQ_FETCH: begin
          if (wt_ready) state_nxt = SEQ_COMPUTE;
        end
        SEQ_COMPUTE: begin
          if (calc_done && !first_q) state_nxt = SEQ_ACTIVATE;
        end
        SEQ_ACTIVATE: begin
          if (is_last) begin
            state_nxt = SEQ_DONE;
          end else begin
            state_nxt = SEQ_FETCH;
            cnt_incr  = 1'b1;
          end
        end
        SEQ_DONE: begin
          state_nxt = SEQ_IDLE;
          cnt_clear = 1'b1;
        end
        default: begin
          state_nxt = SEQ_IDLE;
          cnt_clear = 1'b1;
        end
      endcase
    end
  end

  assign busy       = (state != SEQ_IDLE);
  assign wt_req     = (state == SEQ_FETCH);
  assign wt_layer   = layer;
  assign calc_start = first_q;
  assign act_en     = (state == SEQ_ACTIVATE) && !is_last;
  assign buf_swap   = (state == SEQ_ACTIVATE);
  assign done       = (state == SEQ_DONE);
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Scoreboard bench for mlp_layer_sequencer: expected pulse events are queued
// by the stimulus and popped by an independent monitor.
module tb_mlp_layer_sequencer;

  localparam int NL = 4;
  localparam int LW = 4;

  localparam int EV_CALC  = 0;
  localparam int EV_SWAP  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ABORT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          wt_ready = 1'b0;
  logic          calc_done = 1'b0;
  logic          busy;
  logic          wt_req;
  logic [LW-1:0] wt_layer;
  logic          calc_start;
  logic          act_en;
  logic          buf_swap;
  logic          done;
  logic          aborted;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wt_req_cnt = 0;

  int stall_layer = -1;
  int stall_cycles = 0;
  bit hold_calc = 1'b0;
  bit prev_calc_start = 1'b0;
  int fetch_cnt = 0;

  typedef struct {
    int kind;
    int layer;
    int act;
    int cyc;
  } ev_t;

  ev_t sb[$];

  mlp_layer_sequencer #(.NUM_LAYERS(NL), .LAYER_W(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .wt_ready   (wt_ready),
    .calc_done  (calc_done),
    .busy       (busy),
    .wt_req     (wt_req),
    .wt_layer   (wt_layer),
    .calc_start (calc_start),
    .act_en     (act_en),
    .buf_swap   (buf_swap),
    .done       (done),
    .aborted    (aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int layer, input int act, input int c);
    ev_t e;
    e.kind = kind;
    e.layer = layer;
    e.act = act;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Expected events of one full inference; a stalled layer lengthens its FETCH.
  task automatic push_run(input int t, input int done_off);
    int c;
    int fl;
    c = t + 1;
    for (int l = 0; l < NL; l++) begin
      fl = 1 + ((l == stall_layer) ? stall_cycles : 0);
      c += fl;
      expect_ev(EV_CALC, l, 0, c);
      expect_ev(EV_SWAP, l, (l < NL - 1) ? 1 : 0, c + 2);
      c += 3;
    end
    expect_ev(EV_DONE, -1, 0, t + done_off);
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) check("wait_cyc", cyc, target);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic pop_check(input int kind, input int layer, input int act);
    ev_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d layer %0d at cycle %0d, expected none",
               kind, layer, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
      if (e.layer >= 0) check("event_layer", layer, e.layer);
      if (kind == EV_SWAP) check("event_act_en", act, e.act);
    end
  endtask

  // Responder: weights after an optional stall, calc_done one cycle after calc_start.
  initial begin
    forever begin
      @(negedge clk);
      if (wt_req) begin
        wt_ready = !((int'(wt_layer) == stall_layer) && (fetch_cnt < stall_cycles));
        fetch_cnt++;
      end else begin
        wt_ready = 1'b0;
        fetch_cnt = 0;
      end
      calc_done = hold_calc | prev_calc_start;
      prev_calc_start = calc_start;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (wt_req) wt_req_cnt++;
    if (calc_start) pop_check(EV_CALC, int'(wt_layer), 0);
    if (buf_swap)   pop_check(EV_SWAP, int'(wt_layer), int'(act_en));
    if (done)       pop_check(EV_DONE, int'(wt_layer), 0);
    if (aborted)    pop_check(EV_ABORT, int'(wt_layer), 0);
    if (act_en)     check("act_en_only_with_swap", int'(buf_swap), 1);
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},       int'(busy), 0);
    check({tag, "_wt_req"},     int'(wt_req), 0);
    check({tag, "_wt_layer"},   int'(wt_layer), 0);
    check({tag, "_calc_start"}, int'(calc_start), 0);
    check({tag, "_act_en"},     int'(act_en), 0);
    check({tag, "_buf_swap"},   int'(buf_swap), 0);
    check({tag, "_done"},       int'(done), 0);
    check({tag, "_aborted"},    int'(aborted), 0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // Basic zero-wait run: start at 10, done at 27
    base = wt_req_cnt;
    push_run(10, 17);
    wait_cyc(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_latency_wt_req", int'(wt_req), 1);
    check("start_latency_layer0", int'(wt_layer), 0);
    drain();
    check("basic_wt_req_cycles", wt_req_cnt - base, 4);
    @(negedge clk);
    check("basic_idle_after", int'(busy), 0);

    // Weight stall of 5 cycles on layer 2
    stall_layer = 2;
    stall_cycles = 5;
    base = wt_req_cnt;
    push_run(40, 22);
    wait_cyc(40);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    check("stall_wt_req_cycles", wt_req_cnt - base, 9);
    stall_layer = -1;
    stall_cycles = 0;

    // calc_done held high throughout
    hold_calc = 1'b1;
    push_run(70, 17);
    wait_cyc(70);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    hold_calc = 1'b0;

    // Abort in second COMPUTE cycle of layer 1, together with calc_done
    expect_ev(EV_CALC, 0, 0, 102);
    expect_ev(EV_SWAP, 0, 1, 104);
    expect_ev(EV_CALC, 1, 0, 106);
    expect_ev(EV_ABORT, 0, 0, 108);
    wait_cyc(100);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(107);
    check("abort_cycle_calc_done", int'(calc_done), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_wt_layer", int'(wt_layer), 0);
    check("abort_no_swap", int'(buf_swap), 0);
    push_run(108, 17);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start while busy (during a stalled layer-0 FETCH) and during DONE
    stall_layer = 0;
    stall_cycles = 3;
    push_run(140, 20);
    wait_cyc(140);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("busy_fetch_still", int'(wt_req), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stall_layer = -1;
    stall_cycles = 0;
    wait_cyc(160);
    check("done_cycle_start_seen", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("after_done_busy", int'(busy), 0);
    @(negedge clk);
    check("after_done_busy2", int'(busy), 0);
    check("after_done_wt_req", int'(wt_req), 0);
    drain();

    // Asynchronous reset mid-FETCH
    wait_cyc(180);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_reset_fetch", int'(wt_req), 1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", int'(busy), 0);

    // Recovery run after reset
    push_run(190, 17);
    wait_cyc(190);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
